// File: rtl/sm83_adr_unit.sv
// sm83_adr_unit: address latch with a +/- step incrementer, a small bank of
// pointer registers with write-back, and a burst sequencer. The burst
// sequencer streams consecutive addresses over a valid/ready handshake.
// All state changes on the falling edge of clk. Reset is synchronous and
// active-low.
module sm83_adr_unit #(
  parameter int AW     = 16,
  parameter int NPTR   = 4,
  parameter int STEP_W = 2,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           ain,
  output logic [AW-1:0]           aout,
  output logic [AW-1:0]           apin,
  input  logic                    ctl_al_we,
  input  logic                    ctl_al_hi_ff,
  input  logic                    ctl_inc_oe,
  input  logic                    ctl_inc_dec,
  input  logic                    ctl_inc_cy,
  input  logic [STEP_W-1:0]       ctl_step,
  input  logic                    ctl_ptr_oe,
  input  logic                    ctl_ptr_we,
  input  logic [$clog2(NPTR)-1:0] ctl_ptr_sel,
  output logic                    inc_co,
  input  logic                    burst_start,
  input  logic [LEN_W-1:0]        burst_len,
  input  logic                    burst_dec,
  input  logic                    burst_ready,
  output logic                    burst_valid,
  output logic                    burst_busy,
  output logic                    burst_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [AW-1:0]     r_al;
  logic [AW-1:0]     w_al_nx;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_nx;
  logic              r_dec;
  logic              w_dec_nx;
  logic [AW-1:0]     r_ptr [NPTR];

  logic              w_idle;
  logic [AW-1:0]     w_step_ext;
  logic [AW:0]       w_sum;
  logic [AW-1:0]     w_inc;
  logic [AW-1:0]     w_ptr_rd;
  logic [AW-1:0]     w_src;
  logic [AW-1:0]     w_burst_nx;
  logic              w_ptr_wr;

  assign w_idle   = (r_state == S_IDLE);
  assign w_ptr_rd = r_ptr[ctl_ptr_sel];
  assign w_ptr_wr = w_idle && ctl_ptr_we;

  // Step adder: one extra bit on top catches both carry-out and borrow-out.
  always_comb begin
    w_step_ext = ctl_inc_cy ? AW'(ctl_step) : '0;
    if (ctl_inc_dec) begin
      w_sum = {1'b0, r_al} - {1'b0, w_step_ext};
    end else begin
      w_sum = {1'b0, r_al} + {1'b0, w_step_ext};
    end
  end

  assign w_inc  = w_sum[AW-1:0];
  assign inc_co = w_sum[AW];

  // Latch source select: pointer beats incrementer beats high-byte-forced beats ain.
  always_comb begin
    // NOTE: every combinational output gets a default before the priority chain, so no latch is inferred.
    w_src = ain;
    if (ctl_ptr_oe) begin
      w_src = w_ptr_rd;
    end else if (ctl_inc_oe) begin
      w_src = w_inc;
    end else if (ctl_al_hi_ff) begin
      w_src = {{(AW-8){1'b1}}, ain[7:0]};
    end
  end

  // While the sequencer owns the latch, or nothing loads it, the pins just see al.
  assign apin = (w_idle && ctl_al_we) ? w_src : r_al;

  assign w_burst_nx = r_dec ? (r_al - AW'(1)) : (r_al + AW'(1));

  // Sequencer next state, next latch value and handshake outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_al_nx     = r_al;
    w_cnt_nx    = r_cnt;
    w_dec_nx    = r_dec;
    burst_valid = 1'b0;
    burst_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (burst_start) begin
          if (burst_len == '0) begin
            w_state_nx = S_DONE;
          end else begin
            w_al_nx    = ain;
            w_cnt_nx   = burst_len;
            w_dec_nx   = burst_dec;
            w_state_nx = S_RUN;
          end
        end else if (ctl_al_we) begin
          w_al_nx = apin;
        end
      end
      S_RUN: begin
        burst_valid = 1'b1;
        if (burst_ready) begin
          w_al_nx  = w_burst_nx;
          w_cnt_nx = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        burst_done = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign aout       = r_al;
  assign burst_busy = !w_idle;

  // Latch, count and sequencer state registers; reset wins over every control input.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_state <= S_IDLE;
      r_al    <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_al    <= w_al_nx;
      r_cnt   <= w_cnt_nx;
      r_dec   <= w_dec_nx;
    end
  end

  // Pointer bank write-back; a same-cycle read still sees the old entry.
  always_ff @(negedge clk) begin
    // NOTE: the pointer bank is cleared on reset, so it stays flops and never maps to a RAM macro.
    if (!reset) begin
      for (int i = 0; i < NPTR; i++) begin
        r_ptr[i] <= '0;
      end
    end else if (w_ptr_wr) begin
      r_ptr[ctl_ptr_sel] <= w_inc;
    end
  end

  // Driving the pointer and the incrementer onto the source mux together is a control bug.
  a_oe_exclusive : assert property (@(negedge clk) disable iff (!reset)
    !(ctl_ptr_oe && ctl_inc_oe));

endmodule

// File: tb/tb_sm83_adr_unit.sv
// Self-checking bench for sm83_adr_unit. A behavioural model tracks the latch,
// the pointers and the remaining burst length. A compare process checks every
// DUT output against that model on each rising edge. Directed steps also pin
// hand-computed values.
module tb_sm83_adr_unit;

  localparam int AW     = 16;
  localparam int NPTR   = 4;
  localparam int STEP_W = 2;
  localparam int LEN_W  = 8;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     ain;
  logic [AW-1:0]     aout;
  logic [AW-1:0]     apin;
  logic              ctl_al_we;
  logic              ctl_al_hi_ff;
  logic              ctl_inc_oe;
  logic              ctl_inc_dec;
  logic              ctl_inc_cy;
  logic [STEP_W-1:0] ctl_step;
  logic              ctl_ptr_oe;
  logic              ctl_ptr_we;
  logic [1:0]        ctl_ptr_sel;
  logic              inc_co;
  logic              burst_start;
  logic [LEN_W-1:0]  burst_len;
  logic              burst_dec;
  logic              burst_ready;
  logic              burst_valid;
  logic              burst_busy;
  logic              burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  sm83_adr_unit #(.AW(AW), .NPTR(NPTR), .STEP_W(STEP_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .ain(ain), .aout(aout), .apin(apin),
    .ctl_al_we(ctl_al_we), .ctl_al_hi_ff(ctl_al_hi_ff), .ctl_inc_oe(ctl_inc_oe),
    .ctl_inc_dec(ctl_inc_dec), .ctl_inc_cy(ctl_inc_cy), .ctl_step(ctl_step),
    .ctl_ptr_oe(ctl_ptr_oe), .ctl_ptr_we(ctl_ptr_we), .ctl_ptr_sel(ctl_ptr_sel),
    .inc_co(inc_co), .burst_start(burst_start), .burst_len(burst_len),
    .burst_dec(burst_dec), .burst_ready(burst_ready), .burst_valid(burst_valid),
    .burst_busy(burst_busy), .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_ok = 1'b0;
  int m_al;
  int m_ptr [NPTR];
  int m_left;
  bit m_done;
  bit m_bdec;
  int t_apin;
  int t_sum;

  function automatic int exp_sum();
    int s;
    s = ctl_inc_cy ? int'(ctl_step) : 0;
    return ctl_inc_dec ? (m_al - s) : (m_al + s);
  endfunction

  function automatic int exp_inc();
    return exp_sum() & 32'hFFFF;
  endfunction

  function automatic int exp_co();
    int t;
    t = exp_sum();
    return (t < 0 || t > 65535) ? 1 : 0;
  endfunction

  function automatic bit exp_busy();
    return (m_left > 0) || m_done;
  endfunction

  function automatic int exp_apin();
    if (exp_busy() || !ctl_al_we) return m_al;
    if (ctl_ptr_oe)   return m_ptr[ctl_ptr_sel];
    if (ctl_inc_oe)   return exp_inc();
    if (ctl_al_hi_ff) return 32'hFF00 | int'(ain[7:0]);
    return int'(ain);
  endfunction

  // Model update on the active (falling) edge.
  always @(negedge clk) begin
    if (!reset) begin
      m_al   = 0;
      for (int i = 0; i < NPTR; i++) m_ptr[i] = 0;
      m_left = 0;
      m_done = 1'b0;
      m_bdec = 1'b0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_left > 0) begin
        if (burst_ready) begin
          m_al   = (m_bdec ? m_al - 1 : m_al + 1) & 32'hFFFF;
          m_left = m_left - 1;
          if (m_left == 0) m_done = 1'b1;
        end
      end else begin
        t_apin = exp_apin();
        t_sum  = exp_inc();
        if (ctl_ptr_we) m_ptr[ctl_ptr_sel] = t_sum;
        if (burst_start) begin
          if (burst_len == 0) begin
            m_done = 1'b1;
          end else begin
            m_al   = int'(ain);
            m_left = int'(burst_len);
            m_bdec = burst_dec;
          end
        end else if (ctl_al_we) begin
          m_al = t_apin;
        end
      end
    end
  end

  // Compare process: all outputs against the model, away from the active edge.
  always @(posedge clk) begin
    if (m_ok) begin
      check("cmp_aout",  32'(aout),        m_al);
      check("cmp_apin",  32'(apin),        exp_apin());
      check("cmp_inc_co", 32'(inc_co),     exp_co());
      check("cmp_valid", 32'(burst_valid), (m_left > 0) ? 1 : 0);
      check("cmp_busy",  32'(burst_busy),  exp_busy() ? 1 : 0);
      check("cmp_done",  32'(burst_done),  m_done ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    ctl_al_we = 0; ctl_al_hi_ff = 0; ctl_inc_oe = 0; ctl_inc_dec = 0;
    ctl_inc_cy = 0; ctl_step = '0; ctl_ptr_oe = 0; ctl_ptr_we = 0;
    ctl_ptr_sel = '0; burst_start = 0; burst_len = '0; burst_dec = 0;
    burst_ready = 0;
  endtask

  task automatic load_al(input logic [AW-1:0] v);
    clear_ctl();
    ain = v; ctl_al_we = 1;
    tick();
    clear_ctl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ain = '0;
    clear_ctl();
    reset = 0;
    tick();
    tick();
    check("rst_aout",  32'(aout), 32'h0);
    check("rst_busy",  32'(burst_busy), 32'h0);
    check("rst_valid", 32'(burst_valid), 32'h0);
    check("rst_done",  32'(burst_done), 32'h0);
    reset = 1;
    tick();

    // 1: increment across the byte boundary, then wrap at the top
    load_al(16'h00FF);
    check("t1_load", 32'(aout), 32'h00FF);
    ctl_inc_oe = 1; ctl_inc_cy = 1; ctl_step = 2'd1; ctl_al_we = 1;
    #2;
    check("t1_apin", 32'(apin), 32'h0100);
    check("t1_co0",  32'(inc_co), 32'h0);
    tick();
    check("t1_aout", 32'(aout), 32'h0100);
    load_al(16'hFFFF);
    ctl_inc_oe = 1; ctl_inc_cy = 1; ctl_step = 2'd1; ctl_al_we = 1;
    #2;
    check("t1_wrap_co", 32'(inc_co), 32'h1);
    tick();
    check("t1_wrap_aout", 32'(aout), 32'h0000);

    // 2: decrement below zero, then carry-in disabled
    load_al(16'h0001);
    ctl_inc_oe = 1; ctl_inc_cy = 1; ctl_inc_dec = 1; ctl_step = 2'd2; ctl_al_we = 1;
    #2;
    check("t2_apin", 32'(apin), 32'hFFFF);
    check("t2_co",   32'(inc_co), 32'h1);
    ctl_inc_cy = 0;
    #1;
    check("t2_nocy_apin", 32'(apin), 32'h0001);
    check("t2_nocy_co",   32'(inc_co), 32'h0);
    ctl_al_we = 0;
    tick();
    clear_ctl();

    // 3: forced high byte, pointer write-back and read
    clear_ctl();
    ain = 16'h1234; ctl_al_hi_ff = 1; ctl_al_we = 1;
    tick();
    check("t3_hiff", 32'(aout), 32'hFF34);
    load_al(16'hC000);
    ctl_ptr_we = 1; ctl_ptr_sel = 2'd2; ctl_inc_cy = 1; ctl_step = 2'd1;
    tick();
    clear_ctl();
    ctl_ptr_oe = 1; ctl_ptr_sel = 2'd2; ctl_al_we = 1;
    tick();
    check("t3_ptr_rd", 32'(aout), 32'hC001);
    // write and read the same pointer together: read sees the old entry
    ctl_ptr_we = 1; ctl_inc_cy = 1; ctl_step = 2'd1;
    tick();
    check("t3_rd_old", 32'(aout), 32'hC001);
    ctl_ptr_we = 0; ctl_inc_cy = 0;
    tick();
    check("t3_rd_new", 32'(aout), 32'hC002);
    clear_ctl();

    // 4: upward burst of three with a stalled beat
    ain = 16'h8000; burst_start = 1; burst_len = 8'd3;
    tick();
    burst_start = 0; burst_ready = 1;
    check("t4_a0", 32'(aout), 32'h8000);
    check("t4_v0", 32'(burst_valid), 32'h1);
    tick();
    burst_ready = 0;
    check("t4_a1", 32'(aout), 32'h8001);
    tick();
    check("t4_a1_hold", 32'(aout), 32'h8001);
    check("t4_v_hold",  32'(burst_valid), 32'h1);
    burst_ready = 1;
    tick();
    check("t4_a2", 32'(aout), 32'h8002);
    tick();
    burst_ready = 0;
    check("t4_done", 32'(burst_done), 32'h1);
    check("t4_done_v", 32'(burst_valid), 32'h0);
    tick();
    check("t4_done_end", 32'(burst_done), 32'h0);
    check("t4_idle",     32'(burst_busy), 32'h0);

    // 5: zero-length burst, then a downward burst wrapping below zero
    burst_start = 1; burst_len = 8'd0; ain = 16'h4444;
    tick();
    burst_start = 0;
    check("t5_len0_done", 32'(burst_done), 32'h1);
    check("t5_len0_v",    32'(burst_valid), 32'h0);
    check("t5_len0_al",   32'(aout), 32'h8003);
    tick();
    ain = 16'h0000; burst_start = 1; burst_len = 8'd2; burst_dec = 1;
    tick();
    burst_start = 0; burst_ready = 1;
    check("t5_d0", 32'(aout), 32'h0000);
    tick();
    check("t5_d1", 32'(aout), 32'hFFFF);
    tick();
    burst_ready = 0;
    check("t5_done", 32'(burst_done), 32'h1);
    tick();
    clear_ctl();

    // 6: controls ignored during a burst, then reset aborts it
    ain = 16'h1000; burst_start = 1; burst_len = 8'd5;
    tick();
    clear_ctl();
    ain = 16'hABCD; ctl_al_we = 1; ctl_ptr_we = 1; ctl_ptr_sel = 2'd1;
    ctl_inc_cy = 1; ctl_step = 2'd3;
    tick();
    check("t6_ignored", 32'(aout), 32'h1000);
    check("t6_busy",    32'(burst_busy), 32'h1);
    reset = 0;
    tick();
    check("t6_rst_busy",  32'(burst_busy), 32'h0);
    check("t6_rst_valid", 32'(burst_valid), 32'h0);
    check("t6_rst_aout",  32'(aout), 32'h0);
    reset = 1;
    clear_ctl();
    tick();
    check("t6_no_done", 32'(burst_done), 32'h0);
    ctl_ptr_oe = 1; ctl_ptr_sel = 2'd2; ctl_al_we = 1;
    #2;
    check("t6_ptr_clr", 32'(apin), 32'h0);
    tick();
    clear_ctl();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
